// File: rtl/alu_logic_seq.sv
// Multicycle bitwise logic unit: AND/NAND/OR/NOR/XOR/XNOR evaluated SLICE bits per clock, LSB first.
// Optional registered parity output enabled by defining ALU_LOGIC_SEQ_PARITY_EN.
module alu_logic_seq #(
  parameter int WIDTH = 32,
  parameter int SLICE = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             err,
  output logic             parity
);

  localparam int NSL  = WIDTH / SLICE;
  localparam int IDXW = (NSL > 1) ? $clog2(NSL) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]       state;
  logic [IDXW-1:0]  idx;
  logic [WIDTH-1:0] a_q, b_q, acc, acc_nxt;
  logic [2:0]       op_q;
  logic             accept, op_legal, last;

  // op[2:1] selects the base function, op[0] inverts it
  function automatic logic [SLICE-1:0] slice_op(input logic [2:0] code,
                                                 input logic [SLICE-1:0] x,
                                                 input logic [SLICE-1:0] y);
    logic [SLICE-1:0] r;
    case (code[2:1])
      2'b00:   r = x & y;
      2'b01:   r = x | y;
      default: r = x ^ y;
    endcase
    return code[0] ? ~r : r;
  endfunction

  assign accept   = start && ((state == IDLE) || (state == FIN));
  assign op_legal = (op[2:1] != 2'b11);
  assign last     = (idx == IDXW'(NSL - 1));

  always_comb begin
    acc_nxt = acc;
    acc_nxt[int'(idx)*SLICE +: SLICE] = slice_op(op_q, a_q[int'(idx)*SLICE +: SLICE],
                                                 b_q[int'(idx)*SLICE +: SLICE]);
  end

  // Operand capture and slice accumulator: data only, no reset needed
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
    end
    if (state == RUN) acc <= acc_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, FIN: begin
          if (start) begin
            idx <= '0;
            err <= !op_legal;
            if (op_legal) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state  <= FIN;
              result <= '0;
              zero   <= 1'b1;
              done   <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (last) begin
            idx    <= '0;
            result <= acc_nxt;
            zero   <= (acc_nxt == '0);
            busy   <= 1'b0;
            done   <= 1'b1;
            state  <= FIN;
          end else begin
            idx <= idx + IDXW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_LOGIC_SEQ_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   parity <= 1'b0;
    else if (state == RUN && last) parity <= ^acc_nxt;
    else if (accept && !op_legal)  parity <= 1'b0;
  end
`else
  assign parity = 1'b0;
`endif

endmodule

// File: tb/tb_alu_logic_seq.sv
// Directed bench for alu_logic_seq (WIDTH=32, SLICE=8) with hand-computed expected values.
module tb_alu_logic_seq;

  logic        clk, rst_n, start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, zero, err, parity;
  logic [31:0] result;

  int errors = 0;
  int checks = 0;
  int cyc;

`ifdef ALU_LOGIC_SEQ_PARITY_EN
  localparam bit PE = 1'b1;
`else
  localparam bit PE = 1'b0;
`endif

  alu_logic_seq #(.WIDTH(32), .SLICE(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .zero(zero), .err(err), .parity(parity)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one start edge, then wait (bounded) for done; n = edges after E0
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int n);
    op = o; a = x; b = y; start = 1'b1;
    step();
    start = 1'b0;
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic wait_done(inout int n);
    while (!done && n < 20) begin
      step();
      n++;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; op = 3'b000; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_zero", {31'b0, zero}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_parity", {31'b0, parity}, 32'd0);
    rst_n = 1'b1;
    step();

    // 1. NAND, busy for exactly 4 cycles
    op = 3'b001; a = 32'hFFFF0000; b = 32'h0F0F0F0F; start = 1'b1;
    step();
    start = 1'b0;
    chk("t1_busy_e0", {31'b0, busy}, 32'd1);
    cyc = 0;
    while (busy && cyc < 20) begin
      step();
      cyc++;
    end
    chk("t1_busy_cycles", cyc, 32'd4);
    chk("t1_done", {31'b0, done}, 32'd1);
    chk("t1_result", result, 32'hF0F0FFFF);
    chk("t1_zero", {31'b0, zero}, 32'd0);
    chk("t1_err", {31'b0, err}, 32'd0);
    chk("t1_parity", {31'b0, parity}, 32'd0);
    step();
    chk("t1_done_pulse", {31'b0, done}, 32'd0);

    // 2. AND to zero
    issue(3'b000, 32'hAAAAAAAA, 32'h55555555, cyc);
    chk("t2_lat", cyc, 32'd4);
    chk("t2_result", result, 32'h0);
    chk("t2_zero", {31'b0, zero}, 32'd1);
    chk("t2_parity", {31'b0, parity}, 32'd0);
    step();

    // 3. Illegal op: done straight after the start edge, busy never high
    issue(3'b110, 32'h12345678, 32'h9ABCDEF0, cyc);
    chk("t3_lat", cyc, 32'd0);
    chk("t3_busy", {31'b0, busy}, 32'd0);
    chk("t3_result", result, 32'h0);
    chk("t3_zero", {31'b0, zero}, 32'd1);
    chk("t3_err", {31'b0, err}, 32'd1);
    step();
    chk("t3_done_pulse", {31'b0, done}, 32'd0);

    // 4. XOR with a second start mid-run carrying different operands
    op = 3'b100; a = 32'h12345678; b = 32'hFFFFFFFF; start = 1'b1;
    step();
    start = 1'b0;
    step();
    op = 3'b000; a = 32'h0; b = 32'h0; start = 1'b1;
    step();
    start = 1'b0;
    cyc = 2;
    wait_done(cyc);
    chk("t4_lat", cyc, 32'd4);
    chk("t4_result", result, 32'hEDCBA987);
    chk("t4_err", {31'b0, err}, 32'd0);
    chk("t4_parity", {31'b0, parity}, {31'b0, PE});
    step();

    // 5. Reset during RUN of OR aborts without done
    op = 3'b010; a = 32'h00FF00FF; b = 32'h0F000F00; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_result", result, 32'h0);
    chk("t5_parity", {31'b0, parity}, 32'd0);
    cyc = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (done) cyc++;
    end
    chk("t5_no_done", cyc, 32'd0);
    rst_n = 1'b1;
    step();
    issue(3'b011, 32'h0, 32'h0, cyc);
    chk("t5_nor_lat", cyc, 32'd4);
    chk("t5_nor_result", result, 32'hFFFFFFFF);
    chk("t5_nor_zero", {31'b0, zero}, 32'd0);
    step();

    // 6. Back-to-back: start accepted in the FIN cycle
    issue(3'b000, 32'hFFFF0000, 32'h00FFFF00, cyc);
    chk("t6_first_result", result, 32'h00FF0000);
    op = 3'b101; a = 32'h0; b = 32'h0; start = 1'b1;
    step();
    start = 1'b0;
    chk("t6_busy", {31'b0, busy}, 32'd1);
    chk("t6_done_drop", {31'b0, done}, 32'd0);
    cyc = 1;
    wait_done(cyc);
    chk("t6_gap", cyc, 32'd5);
    chk("t6_result", result, 32'hFFFFFFFF);
    chk("t6_zero", {31'b0, zero}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
